// File: rtl/sqrt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_rr_arbiter
// Purpose  : Round-robin sharing of one integer square-root core among NUM_REQ
//            clients: grant, operand capture, start, wait for done, ack.
// Options  : SQRT_ARB_TIMEOUT_EN adds a WAIT-state watchdog with core abort.
// Revision : 1.0  initial release
// ============================================================================
module sqrt_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ROOT_W  = 8,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] operand_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [ROOT_W-1:0]         root_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [IDX_W-1:0]          owner_o,
  output logic                      core_start_o,
  output logic [DATA_W-1:0]         core_operand_o,
  input  logic                      core_done_i,
  input  logic [ROOT_W-1:0]         core_root_i,
  output logic                      core_abort_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  if (NUM_REQ < 2 || DATA_W != 2 * ROOT_W || (1 << IDX_W) < NUM_REQ || TIMEOUT < 2)
  begin : g_param_check
    $error("sqrt_rr_arbiter: inconsistent parameter set");
  end

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [DATA_W-1:0]   r_operand;
  logic [ROOT_W-1:0]   r_root;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_start;
  logic                r_busy;

  logic                w_gnt_vld;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [DATA_W-1:0]   w_gnt_op;
  logic [NUM_REQ-1:0]  w_owner_oh;

  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from farthest to nearest so the last hit is the first set bit after r_ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[f_wrap(r_ptr, i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = f_wrap(r_ptr, i);
      end
    end
  end

  assign w_gnt_op = operand_i[int'(w_gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    w_owner_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_owner_oh[k] = (int'(r_owner) == k);
    end
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int              c_CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_err;
  logic               r_abort;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
      r_owner    <= '0;
      r_operand  <= '0;
      r_root     <= '0;
      r_ack      <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
      r_abort    <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_ack   <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
      r_abort <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_owner   <= w_gnt_idx;
            r_operand <= w_gnt_op;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef SQRT_ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the last watchdog cycle still wins.
          if (core_done_i) begin
            r_root  <= core_root_i;
            r_ack   <= w_owner_oh;
            r_state <= ST_RESP;
`ifdef SQRT_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
          end
`ifdef SQRT_ARB_TIMEOUT_EN
          else if (r_wait_cnt == c_WAIT_LAST) begin
            r_root  <= '0;
            r_err   <= 1'b1;
            r_abort <= 1'b1;
            r_ack   <= w_owner_oh;
            r_state <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
          end
`endif
        end
        ST_RESP: begin
          r_ptr   <= r_owner;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack_o          = r_ack;
  assign root_o         = r_root;
  assign busy_o         = r_busy;
  assign owner_o        = r_owner;
  assign core_start_o   = r_start;
  assign core_operand_o = r_operand;

`ifdef SQRT_ARB_TIMEOUT_EN
  assign err_o        = r_err;
  assign core_abort_o = r_abort;
`else
  assign err_o        = 1'b0;
  assign core_abort_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sqrt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_rr_arbiter
// Purpose  : Randomized and directed checking of sqrt_rr_arbiter against a
//            job-level round-robin model with a delay-programmable core model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sqrt_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ROOT_W  = 8;
  localparam int IDX_W   = 2;
`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 1024;
`endif

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] operand;
  logic [NUM_REQ-1:0]        ack_o;
  logic [ROOT_W-1:0]         root_o;
  logic                      err_o;
  logic                      busy_o;
  logic [IDX_W-1:0]          owner_o;
  logic                      core_start_o;
  logic [DATA_W-1:0]         core_operand_o;
  logic                      core_done;
  logic [ROOT_W-1:0]         core_root;
  logic                      core_abort_o;

  sqrt_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ROOT_W(ROOT_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req),
    .operand_i      (operand),
    .ack_o          (ack_o),
    .root_o         (root_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .owner_o        (owner_o),
    .core_start_o   (core_start_o),
    .core_operand_o (core_operand_o),
    .core_done_i    (core_done),
    .core_root_i    (core_root),
    .core_abort_o   (core_abort_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] c_op [NUM_REQ];
  int                mode [NUM_REQ];   // 0 random, 1 re-request at once, 2 passive
  bit                drop [NUM_REQ];
  int                p_req;
  int                force_L;

  always_comb begin
    operand = '0;
    for (int k = 0; k < NUM_REQ; k++) operand[k*DATA_W +: DATA_W] = c_op[k];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic t_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (cycle time %0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int f_isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int f_pick(input int ptr, input logic [NUM_REQ-1:0] r);
    for (int i = 1; i <= NUM_REQ; i++)
      if (r[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    return -1;
  endfunction

  // Job-level reference model.
  int                cyc;
  int                m_ptr, m_owner, m_g, m_L, m_ack_cyc, m_free_at;
  bit                m_active, m_tmo, m_err;
  logic [DATA_W-1:0] m_op;
  logic [ROOT_W-1:0] m_root;
  int                core_cnt;
  int                grants[$];
  int                last_ack_cyc, last_start_cyc, last_abort_cyc;

  function automatic int g_at(input int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction

  task automatic model_reset();
    m_ptr = NUM_REQ - 1; m_active = 0; m_free_at = 0; m_ack_cyc = -1; m_g = -1;
    m_op = '0; m_root = '0; m_err = 0; m_tmo = 0; m_owner = 0; m_L = 1;
  endtask

  task automatic chk_zero(input string tag);
    t_check({tag, "_ack"},   ack_o, 0);
    t_check({tag, "_root"},  root_o, 0);
    t_check({tag, "_err"},   err_o, 0);
    t_check({tag, "_busy"},  busy_o, 0);
    t_check({tag, "_owner"}, owner_o, 0);
    t_check({tag, "_start"}, core_start_o, 0);
    t_check({tag, "_op"},    core_operand_o, 0);
    t_check({tag, "_abort"}, core_abort_o, 0);
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] e_ack;
    bit in_job;
    @(posedge clk);
    cyc++;
    if (cyc >= m_free_at && req != '0) begin
      m_owner   = f_pick(m_ptr, req);
      m_op      = c_op[m_owner];
      m_g       = cyc;
      m_L       = (force_L >= 0) ? force_L : int'($urandom_range(1, 6));
      m_tmo     = (m_L > TIMEOUT - 1);
      m_ack_cyc = m_tmo ? cyc + TIMEOUT + 1 : cyc + m_L + 2;
      m_free_at = m_ack_cyc + 2;
      m_ptr     = m_owner;
      m_active  = 1;
    end
    @(negedge clk);
    in_job = m_active && cyc >= m_g && cyc <= m_ack_cyc;
    e_ack  = '0;
    if (m_active && cyc == m_ack_cyc) begin
      e_ack[m_owner] = 1'b1;
      m_root = m_tmo ? '0 : ROOT_W'(f_isqrt(int'(m_op)));
      m_err  = m_tmo;
    end
    t_check("ack",     ack_o, e_ack);
    t_check("busy",    busy_o, in_job);
    t_check("start",   core_start_o, m_active && cyc == m_g);
    t_check("abort",   core_abort_o, m_active && m_tmo && cyc == m_ack_cyc);
    t_check("root",    root_o, m_root);
    t_check("err",     err_o, m_err);
    t_check("operand", core_operand_o, m_op);
    if (in_job) t_check("owner", owner_o, m_owner);
    if (ack_o != '0) last_ack_cyc = cyc;
    if (core_start_o) begin
      grants.push_back(int'(owner_o));
      last_start_cyc = cyc;
    end
    if (core_abort_o) last_abort_cyc = cyc;

    // Core model: done is presented L cycles after the core registers start.
    if (core_done) core_done = 1'b0;
    if (core_abort_o) core_cnt = 0;
    if (core_start_o) core_cnt = m_L + 1;
    else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_root = ROOT_W'(f_isqrt(int'(core_operand_o)));
      end
    end

    for (int k = 0; k < NUM_REQ; k++) begin
      if (m_active && cyc == m_ack_cyc && m_owner == k) drop[k] = 1;
      else if (drop[k]) begin
        drop[k] = 0;
        req[k]  = 1'b0;
      end else if (!req[k]) begin
        if (mode[k] == 1 || (mode[k] == 0 && int'($urandom_range(0, 15)) < p_req)) begin
          c_op[k] = DATA_W'($urandom);
          req[k]  = 1'b1;
        end
      end else if (mode[k] == 0 && $urandom_range(0, 7) == 0) begin
        c_op[k] = DATA_W'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    model_reset();
    core_cnt  = 0;
    core_done = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) drop[k] = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_modes(input int m);
    for (int k = 0; k < NUM_REQ; k++) mode[k] = m;
  endtask

  initial begin
    int t1_c;
    rst_n = 1'b0; req = '0; core_done = 1'b0; core_root = '0;
    for (int k = 0; k < NUM_REQ; k++) begin c_op[k] = '0; drop[k] = 0; end
    set_modes(2);
    p_req = 0; force_L = -1; cyc = 0; core_cnt = 0;
    last_ack_cyc = -1; last_start_cyc = -1; last_abort_cyc = -1;
    model_reset();
    @(negedge clk);
    chk_zero("por");
    rst_n = 1'b1;

    // Single client, fixed core delay of 5.
    force_L = 5; c_op[0] = 16'd144; req[0] = 1'b1; t1_c = cyc;
    repeat (12) tick();
    t_check("t1_latency", last_ack_cyc - t1_c, 8);
    t_check("t1_root", root_o, 12);

    // Reset during WAIT drops the job and restores client-0 priority.
    c_op[1] = 16'd1000; req[1] = 1'b1;
    repeat (4) tick();
    do_reset();
    c_op[0] = 16'd49; req[0] = 1'b1; grants.delete();
    repeat (30) tick();
    t_check("t4_first_grant", g_at(0), 0);
    t_check("t4_second_grant", g_at(1), 1);

    // Stray done while idle.
    repeat (5) tick();
    core_done = 1'b1; core_root = 8'd99;
    tick(); tick();
    t_check("t5_root", root_o, 31);
    t_check("t5_busy", busy_o, 0);

    // All four requesting from reset.
    force_L = -1;
    do_reset();
    c_op[0] = 16'd100; c_op[1] = 16'd400; c_op[2] = 16'd900; c_op[3] = 16'd2500;
    req = '1; grants.delete();
    repeat (60) tick();
    for (int i = 0; i < NUM_REQ; i++) t_check("t2_order", g_at(i), i);

    // Clients 0 and 2 keep re-requesting.
    do_reset();
    mode[0] = 1; mode[2] = 1; grants.delete();
    repeat (60) tick();
    for (int i = 0; i < 4; i++) t_check("t3_alternate", g_at(i), (i % 2) * 2);
    set_modes(2);
    repeat (30) tick();

`ifdef SQRT_ARB_TIMEOUT_EN
    do_reset();
    force_L = TIMEOUT + 3; c_op[3] = 16'd625; req[3] = 1'b1;
    repeat (TIMEOUT + 8) tick();
    t_check("t6_abort_delay", last_abort_cyc - last_start_cyc, TIMEOUT + 1);
    t_check("t6_err", err_o, 1);
    t_check("t6_root", root_o, 0);
    force_L = -1;
`endif

    do_reset();
    set_modes(0);
    for (int ph = 0; ph < 3; ph++) begin
      p_req = 2 + ph * 6;
      repeat (600) tick();
    end
    set_modes(2);
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
